// File: rtl/vga_frame_scheduler.sv
// Shadows CPU result words and commits them to colorpart on frame end (output 1 cycle after picture_over_i).
// Writes are refused only during the picture_over_i cycle, so a commit never races an accept.
module vga_frame_scheduler (
  input  logic        vga_clk_i,
  input  logic        rst_i,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  input  logic        wr_sel_i,
  input  logic [31:0] wr_data_i,
  input  logic        display_req_i,
  input  logic        picture_over_i,
  output logic [31:0] chicken_o,
  output logic [31:0] rabbit_o,
  output logic        display_en_o,
  output logic        commit_o,
  output logic [15:0] frame_cnt_o,
  output logic [7:0]  overwrite_cnt_o
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ARM   = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } disp_state_t;

  disp_state_t state, state_nxt;

  logic [31:0] sh_chicken;
  logic [31:0] sh_rabbit;
  logic        pend_c;
  logic        pend_r;
  logic        accept;
  logic        overwrite;

  assign wr_ready_o = ~picture_over_i;
  assign accept     = wr_valid_i & wr_ready_o;
  assign overwrite  = accept & (wr_sel_i ? pend_r : pend_c);

  always_ff @(posedge vga_clk_i) begin
    if (rst_i) begin
      sh_chicken      <= '0;
      sh_rabbit       <= '0;
      pend_c          <= 1'b0;
      pend_r          <= 1'b0;
      chicken_o       <= '0;
      rabbit_o        <= '0;
      commit_o        <= 1'b0;
      overwrite_cnt_o <= '0;
    end else begin
      commit_o <= picture_over_i & (pend_c | pend_r);
      // accept and commit are mutually exclusive, so pend set/clear never collide
      if (picture_over_i) begin
        if (pend_c) begin
          chicken_o <= sh_chicken;
          pend_c    <= 1'b0;
        end
        if (pend_r) begin
          rabbit_o <= sh_rabbit;
          pend_r   <= 1'b0;
        end
      end else if (accept) begin
        if (wr_sel_i) begin
          sh_rabbit <= wr_data_i;
          pend_r    <= 1'b1;
        end else begin
          sh_chicken <= wr_data_i;
          pend_c     <= 1'b1;
        end
      end
      if (overwrite && overwrite_cnt_o != 8'hFF) begin
        overwrite_cnt_o <= overwrite_cnt_o + 8'd1;
      end
    end
  end

  always_ff @(posedge vga_clk_i) begin
    if (rst_i) begin
      state       <= ST_OFF;
      frame_cnt_o <= '0;
    end else begin
      state <= state_nxt;
      if (picture_over_i && (state == ST_ON || state == ST_DRAIN)) begin
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF:   if (display_req_i) state_nxt = ST_ARM;
      ST_ARM: begin
        if (!display_req_i)      state_nxt = ST_OFF;
        else if (picture_over_i) state_nxt = ST_ON;
      end
      ST_ON:    if (!display_req_i) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (display_req_i)       state_nxt = ST_ON;
        else if (picture_over_i) state_nxt = ST_OFF;
      end
      default:  state_nxt = ST_OFF;
    endcase
  end

  assign display_en_o = (state == ST_ON) || (state == ST_DRAIN);

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Directed bench for vga_frame_scheduler: commit timing, overwrite saturation, display sequencing, reset.
module tb_vga_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_sel;
  logic [31:0] wr_data;
  logic        display_req;
  logic        picture_over;
  logic [31:0] chicken;
  logic [31:0] rabbit;
  logic        display_en;
  logic        commit;
  logic [15:0] frame_cnt;
  logic [7:0]  overwrite_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_frame_scheduler dut (
    .vga_clk_i      (clk),
    .rst_i          (rst),
    .wr_valid_i     (wr_valid),
    .wr_ready_o     (wr_ready),
    .wr_sel_i       (wr_sel),
    .wr_data_i      (wr_data),
    .display_req_i  (display_req),
    .picture_over_i (picture_over),
    .chicken_o      (chicken),
    .rabbit_o       (rabbit),
    .display_en_o   (display_en),
    .commit_o       (commit),
    .frame_cnt_o    (frame_cnt),
    .overwrite_cnt_o(overwrite_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    picture_over = 1'b1;
    step();
    picture_over = 1'b0;
  endtask

  task automatic write(input logic sel, input logic [31:0] data);
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_data  = data;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; wr_sel = 1'b0; wr_data = '0;
    display_req = 1'b0; picture_over = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (10) step();
    checks++;
    if ({chicken, rabbit} !== 64'h0) begin
      errors++; $display("FAIL reset_words: got %h %h expected 0 0", chicken, rabbit);
    end
    checks++;
    if ({display_en, commit, frame_cnt, overwrite_cnt} !== 26'h0) begin
      errors++; $display("FAIL reset_ctrl: got en=%b commit=%b fc=%h ov=%h expected all 0",
                         display_en, commit, frame_cnt, overwrite_cnt);
    end
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", wr_ready);
    end
  endtask

  task automatic test_commit();
    write(1'b0, 32'h12345678);
    repeat (14) step();
    picture_over = 1'b1;
    #1;
    checks++;
    if (chicken !== 32'h0) begin
      errors++; $display("FAIL commit_before: got %h expected 00000000", chicken);
    end
    step();
    picture_over = 1'b0;
    checks++;
    if (chicken !== 32'h12345678 || commit !== 1'b1) begin
      errors++; $display("FAIL commit_after: got %h commit=%b expected 12345678 commit=1", chicken, commit);
    end
    checks++;
    if (rabbit !== 32'h0) begin
      errors++; $display("FAIL commit_rabbit: got %h expected 00000000", rabbit);
    end
    step();
    checks++;
    if (commit !== 1'b0) begin
      errors++; $display("FAIL commit_width: got %b expected 0", commit);
    end
  endtask

  task automatic test_overwrite();
    write(1'b1, 32'd1);
    write(1'b1, 32'd2);
    write(1'b1, 32'd3);
    checks++;
    if (overwrite_cnt !== 8'd2) begin
      errors++; $display("FAIL ovw_count: got %0d expected 2", overwrite_cnt);
    end
    pulse();
    checks++;
    if (rabbit !== 32'd3 || commit !== 1'b1) begin
      errors++; $display("FAIL ovw_last_wins: got %h commit=%b expected 3 commit=1", rabbit, commit);
    end
    wr_valid = 1'b1; wr_sel = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wr_data = 32'h1000 + i;
      step();
    end
    wr_valid = 1'b0;
    checks++;
    if (overwrite_cnt !== 8'd255) begin
      errors++; $display("FAIL ovw_saturate: got %0d expected 255", overwrite_cnt);
    end
    pulse();
    checks++;
    if (rabbit !== 32'h112B) begin
      errors++; $display("FAIL ovw_commit: got %h expected 0000112b", rabbit);
    end
  endtask

  task automatic test_hold_during_pulse();
    wr_valid = 1'b1; wr_sel = 1'b0; wr_data = 32'hAA;
    picture_over = 1'b1;
    #1;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++; $display("FAIL hold_ready: got %b expected 0", wr_ready);
    end
    step();
    picture_over = 1'b0;
    checks++;
    if (chicken !== 32'h12345678 || commit !== 1'b0) begin
      errors++; $display("FAIL hold_no_race: got %h commit=%b expected 12345678 commit=0", chicken, commit);
    end
    step();
    wr_valid = 1'b0;
    step();
    checks++;
    if (chicken !== 32'h12345678) begin
      errors++; $display("FAIL hold_pending: got %h expected 12345678", chicken);
    end
    pulse();
    checks++;
    if (chicken !== 32'hAA || commit !== 1'b1) begin
      errors++; $display("FAIL hold_commit: got %h commit=%b expected 000000aa commit=1", chicken, commit);
    end
    pulse();
    pulse();
    checks++;
    if (commit !== 1'b0) begin
      errors++; $display("FAIL idle_pulses: got commit=%b expected 0", commit);
    end
  endtask

  task automatic test_display();
    repeat (3) step();
    display_req = 1'b1;
    repeat (5) step();
    checks++;
    if (display_en !== 1'b0) begin
      errors++; $display("FAIL disp_arm: got %b expected 0", display_en);
    end
    pulse();
    checks++;
    if (display_en !== 1'b1 || frame_cnt !== 16'd0) begin
      errors++; $display("FAIL disp_on: got en=%b fc=%0d expected en=1 fc=0", display_en, frame_cnt);
    end
    repeat (4) step();
    pulse();
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++; $display("FAIL disp_on_frame: got %0d expected 1", frame_cnt);
    end
    repeat (3) step();
    display_req = 1'b0;
    repeat (5) step();
    checks++;
    if (display_en !== 1'b1) begin
      errors++; $display("FAIL disp_drain: got %b expected 1", display_en);
    end
    pulse();
    checks++;
    if (display_en !== 1'b0 || frame_cnt !== 16'd2) begin
      errors++; $display("FAIL disp_off: got en=%b fc=%0d expected en=0 fc=2", display_en, frame_cnt);
    end
    // ARM with request dropping on the pulse cycle goes back to OFF
    display_req = 1'b1;
    step();
    display_req = 1'b0;
    pulse();
    pulse();
    checks++;
    if (display_en !== 1'b0 || frame_cnt !== 16'd2) begin
      errors++; $display("FAIL disp_arm_tie: got en=%b fc=%0d expected en=0 fc=2", display_en, frame_cnt);
    end
  endtask

  task automatic test_wrap_and_reset();
    display_req = 1'b1;
    step();
    pulse();
    picture_over = 1'b1;
    repeat (65533) step();
    picture_over = 1'b0;
    checks++;
    if (frame_cnt !== 16'hFFFF || display_en !== 1'b1) begin
      errors++; $display("FAIL wrap_pre: got fc=%h en=%b expected ffff en=1", frame_cnt, display_en);
    end
    pulse();
    checks++;
    if (frame_cnt !== 16'h0000) begin
      errors++; $display("FAIL wrap: got %h expected 0000", frame_cnt);
    end
    write(1'b0, 32'h55);
    write(1'b0, 32'h66);
    rst = 1'b1;
    picture_over = 1'b1;
    #1;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++; $display("FAIL rst_ready: got %b expected 0", wr_ready);
    end
    step();
    picture_over = 1'b0;
    rst = 1'b0;
    display_req = 1'b0;
    checks++;
    if ({chicken, rabbit, display_en, commit, frame_cnt, overwrite_cnt} !== 90'h0) begin
      errors++; $display("FAIL rst_clear: got c=%h r=%h en=%b cm=%b fc=%h ov=%h expected all 0",
                         chicken, rabbit, display_en, commit, frame_cnt, overwrite_cnt);
    end
    step();
    pulse();
    checks++;
    if (chicken !== 32'h0 || commit !== 1'b0) begin
      errors++; $display("FAIL rst_drop_pend: got %h commit=%b expected 0 commit=0", chicken, commit);
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_overwrite();
    test_hold_during_pulse();
    test_display();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_scheduler.md
# vga_frame_scheduler

Frame-synchronous controller between the CPU result registers and the VGA colour path. Accepts chicken/rabbit result words over a valid/ready port into shadow registers and commits them to the display-facing registers only at frame boundaries, so a frame never shows a mix of old and new values. It also sequences display enable on/off at frame boundaries and keeps frame and overwrite statistics. Sits in the VGA clock domain between the CPU-side result outputs and colorpart, driven by the frame-end pulse from VGA_ctr.

## Interface
- No parameters.
- vga_clk_i  in  1  VGA pixel clock; the block's only clock.
- rst_i  in  1  synchronous, active-high reset.
- wr_valid_i  in  1  write request; all inputs are already synchronous to vga_clk_i.
- wr_ready_o  out  1  write accept.
- wr_sel_i  in  1  target: 0 = chicken, 1 = rabbit.
- wr_data_i  in  32  result word.
- display_req_i  in  1  level request to show results (output_display).
- picture_over_i  in  1  one-cycle pulse at end of each frame's active area.
- chicken_o  out  32  committed chicken word to colorpart.
- rabbit_o  out  32  committed rabbit word to colorpart.
- display_en_o  out  1  colorpart draws results when 1.
- commit_o  out  1  one-cycle pulse: at least one shadow word committed.
- frame_cnt_o  out  16  frames elapsed while display enabled.
- overwrite_cnt_o  out  8  pending shadow words overwritten before commit, saturating.

## Operation
- Shadow: sh_chicken/sh_rabbit (32 bits each), pend_c/pend_r flags.
- wr_ready_o = ~picture_over_i (combinational). Accept = wr_valid_i & wr_ready_o.
- On accept: shadow[sel] <= wr_data_i; pend[sel] <= 1. If pend[sel] was already 1, overwrite_cnt_o += 1, saturating at 255.
- Commit on picture_over_i: for each channel with pend set, output register <= shadow, pend <= 0. commit_o = 1 next cycle iff any pend was set. Commit runs in every display state, including OFF.
- Display FSM states: OFF, ARM, ON, DRAIN.
  - OFF: display_en_o = 0. display_req_i = 1 -> ARM.
  - ARM: display_en_o = 0. display_req_i = 0 -> OFF. picture_over_i -> ON. If both hold in the same cycle, OFF wins.
  - ON: display_en_o = 1. display_req_i = 0 -> DRAIN.
  - DRAIN: display_en_o = 1. display_req_i = 1 -> ON. picture_over_i -> OFF. If both hold in the same cycle, ON wins.
- display_en_o is decoded from the registered state, so enable changes only at frame boundaries.
- frame_cnt_o += 1 on picture_over_i while in ON or DRAIN. It wraps 0xFFFF -> 0x0000 and is not cleared by disable.

## Timing
- Reset values: chicken_o = 0, rabbit_o = 0, shadows = 0, pend = 0, state = OFF, display_en_o = 0, commit_o = 0, frame_cnt_o = 0, overwrite_cnt_o = 0. wr_ready_o follows picture_over_i combinationally, even during reset.
- Reset takes priority over every other event in the same cycle. Reset mid-frame drops pending shadow words without committing them.
- Write accepted in cycle N: shadow valid at N+1. It appears on chicken_o/rabbit_o the cycle after the first picture_over_i at or after N+1.
- A write is never accepted in a picture_over_i cycle, so it cannot race a commit; it must be held until a later cycle.
- picture_over_i in cycle F:
  - outputs, commit_o, frame_cnt_o and state update at F+1.
  - commit_o is high for exactly cycle F+1.
- Back-to-back writes to the same channel between two frame ends: the last one wins; overwrite count = writes − 1.
- Consecutive picture_over_i pulses with no writes: commit_o stays 0.

## Test plan
- Reset, then idle for 10 cycles -> all outputs 0, wr_ready_o = 1, state OFF.
- Write chicken 0x12345678 at cycle 5, picture_over_i at cycle 20 -> chicken_o = 0 through cycle 20, 0x12345678 from cycle 21, commit_o high only at cycle 21, rabbit_o unchanged at 0.
- Three rabbit writes (1, 2, 3) before one frame end -> rabbit_o = 3 after commit, overwrite_cnt_o = 2. Then 300 overwrites -> count saturates at 255.
- wr_valid_i held with data 0xAA during a picture_over_i cycle -> wr_ready_o = 0 that cycle, accepted the next cycle, 0xAA appears only after the following frame end.
- display_req_i rises mid-frame -> display_en_o rises the cycle after the next picture_over_i. display_req_i falls mid-frame -> display_en_o stays 1 until the cycle after the next pulse. frame_cnt_o counts 1 for the ON frame and 1 for the DRAIN frame.
- Start with frame_cnt_o = 0xFFFF and display enabled, send one pulse -> 0x0000. Assert rst_i with a pend flag set -> outputs 0, and no commit at the next pulse.
